// File: rtl/fact_pkg.sv
// Shared constants and types for the factorial accelerator bus interface.
// Register addresses, CTRL/STATUS bit positions and default widths.
package fact_pkg;

    localparam int FACT_N_W = 4;
    localparam int FACT_R_W = 32;

    localparam logic [1:0] FACT_A_N      = 2'd0;
    localparam logic [1:0] FACT_A_CTRL   = 2'd1;
    localparam logic [1:0] FACT_A_STATUS = 2'd2;
    localparam logic [1:0] FACT_A_RESULT = 2'd3;

    localparam int FACT_CTRL_START = 0;
    localparam int FACT_CTRL_IE    = 1;
    localparam int FACT_CTRL_BUSY  = 0;
    localparam int FACT_STAT_DONE  = 0;
    localparam int FACT_STAT_ERR   = 1;

    typedef struct packed {
        logic n;
        logic ctrl;
    } fact_wen_t;

    // Pack two flag bits into a zero-extended 32-bit read word.
    function automatic logic [31:0] fact_flags(
        input int   pos1,
        input logic b1,
        input int   pos0,
        input logic b0
    );
        logic [31:0] w;
        w       = '0;
        w[pos1] = b1;
        w[pos0] = b0;
        return w;
    endfunction

endpackage

// File: rtl/fact_if_dec.sv
// Write decoder for the factorial register interface.
// Only N and CTRL are writable; STATUS/RESULT writes decode to nothing.
module fact_if_dec
    import fact_pkg::*;
(
    input  logic       we_i,
    input  logic [1:0] addr_i,
    output fact_wen_t  wen_o
);

    // One-hot write enable per writable register.
    always_comb begin
        wen_o = '0;
        if (we_i) begin
            case (addr_i)
                FACT_A_N:    wen_o.n    = 1'b1;
                FACT_A_CTRL: wen_o.ctrl = 1'b1;
                default:     wen_o      = '0;
            endcase
        end
    end

endmodule

// File: rtl/fact_if.sv
// Bus-side register interface for the factorial core.
// Optional interrupt output enabled with `define FACT_IF_IRQ_EN.
module fact_if
    import fact_pkg::*;
#(
    parameter int N_W = FACT_N_W,
    parameter int R_W = FACT_R_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           we,
    input  logic [1:0]     addr,
    input  logic [31:0]    wd,
    output logic [31:0]    rd,
    output logic           go,
    output logic [N_W-1:0] n,
    input  logic           core_done,
    input  logic           core_err,
    input  logic [R_W-1:0] core_result
`ifdef FACT_IF_IRQ_EN
    ,
    output logic           irq
`endif
);

    fact_wen_t      wen;
    logic           start;
    logic           finish;
    logic           ie;

    logic [N_W-1:0] n_q, n_d;
    logic           busy_q, busy_d;
    logic           go_q, go_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [R_W-1:0] res_q, res_d;

    fact_if_dec u_dec (
        .we_i   (we),
        .addr_i (addr),
        .wen_o  (wen)
    );

    // A start is taken only when idle; completion only counts while busy,
    // so the core's trailing done cycle falls on an idle interface.
    assign start  = wen.ctrl & wd[FACT_CTRL_START] & ~busy_q;
    assign finish = busy_q & core_done;

    // Next-state for operand, run flags and result capture.
    always_comb begin
        n_d    = n_q;
        busy_d = busy_q;
        go_d   = 1'b0;
        done_d = done_q;
        err_d  = err_q;
        res_d  = res_q;
        if (wen.n && !busy_q) begin
            n_d = wd[N_W-1:0];
        end
        if (start) begin
            busy_d = 1'b1;
            go_d   = 1'b1;
            done_d = 1'b0;
            err_d  = 1'b0;
            res_d  = '0;
        end else if (finish) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            err_d  = core_err;
            res_d  = core_err ? '0 : core_result;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_q    <= '0;
            busy_q <= 1'b0;
            go_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            res_q  <= '0;
        end else begin
            n_q    <= n_d;
            busy_q <= busy_d;
            go_q   <= go_d;
            done_q <= done_d;
            err_q  <= err_d;
            res_q  <= res_d;
        end
    end

`ifdef FACT_IF_IRQ_EN
    logic ie_q, ie_d;
    logic irq_q, irq_d;

    // Interrupt enable follows every CTRL write; irq tracks next done & ie.
    always_comb begin
        ie_d = ie_q;
        if (wen.ctrl) begin
            ie_d = wd[FACT_CTRL_IE];
        end
        irq_d = done_d & ie_d;
    end

    // Interrupt state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ie_q  <= ie_d;
            irq_q <= irq_d;
        end
    end

    assign ie  = ie_q;
    assign irq = irq_q;
`else
    assign ie = 1'b0;
`endif

    assign go = go_q;
    assign n  = n_q;

    // Zero-latency read mux; same-cycle writes are seen next cycle.
    always_comb begin
        rd = '0;
        case (addr)
            FACT_A_N:      rd = 32'(n_q);
            FACT_A_CTRL:   rd = fact_flags(FACT_CTRL_IE, ie,
                                           FACT_CTRL_BUSY, busy_q);
            FACT_A_STATUS: rd = fact_flags(FACT_STAT_ERR, err_q,
                                           FACT_STAT_DONE, done_q);
            FACT_A_RESULT: rd = 32'(res_q);
            default:       rd = '0;
        endcase
    end

endmodule

// File: tb/tb_fact_if.sv
// Directed self-checking bench for fact_if.
// Covers the interrupt path when FACT_IF_IRQ_EN is defined.
module tb_fact_if;
    import fact_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        go;
    logic [3:0]  n;
    logic        core_done;
    logic        core_err;
    logic [31:0] core_result;
`ifdef FACT_IF_IRQ_EN
    logic        irq;
`endif

    int total = 0;
    int bad   = 0;
    int go_cnt = 0;
    int g0;

    fact_if #(.N_W(4), .R_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .we          (we),
        .addr        (addr),
        .wd          (wd),
        .rd          (rd),
        .go          (go),
        .n           (n),
        .core_done   (core_done),
        .core_err    (core_err),
        .core_result (core_result)
`ifdef FACT_IF_IRQ_EN
        ,
        .irq         (irq)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (go) go_cnt <= go_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        we   = 1'b1;
        addr = a;
        wd   = d;
        @(negedge clk);
        we   = 1'b0;
        wd   = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a,
                          input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, rd, exp);
    endtask

    initial begin
        rst = 1'b1;
        we = 1'b0;
        addr = '0;
        wd = '0;
        core_done = 1'b0;
        core_err = 1'b0;
        core_result = '0;
        repeat (2) tick();
        rst = 1'b0;

        rd_chk("rst_n", FACT_A_N, 0);
        rd_chk("rst_ctrl", FACT_A_CTRL, 0);
        rd_chk("rst_stat", FACT_A_STATUS, 0);
        rd_chk("rst_res", FACT_A_RESULT, 0);
        check("rst_go", 32'(go), 0);

        bus_wr(FACT_A_N, 5);
        check("n5", 32'(n), 5);
        rd_chk("rd_n5", FACT_A_N, 5);
        g0 = go_cnt;
        bus_wr(FACT_A_CTRL, 1);
        check("go_t1", 32'(go), 1);
        rd_chk("busy_t1", FACT_A_CTRL, 1);
        tick();
        check("go_t2", 32'(go), 0);
        check("n_hold", 32'(n), 5);
        core_done = 1'b1;
        core_result = 120;
        tick();
        core_result = 77;
        rd_chk("st_done", FACT_A_STATUS, 1);
        rd_chk("res120", FACT_A_RESULT, 120);
        rd_chk("ctrl_idle", FACT_A_CTRL, 0);
        tick();
        core_done = 1'b0;
        core_result = '0;
        rd_chk("res_2nd_done", FACT_A_RESULT, 120);
        check("go_once", 32'(go_cnt - g0), 1);

        bus_wr(FACT_A_STATUS, 0);
        bus_wr(FACT_A_RESULT, 0);
        rd_chk("ro_stat", FACT_A_STATUS, 1);
        rd_chk("ro_res", FACT_A_RESULT, 120);

        @(negedge clk);
        we = 1'b1;
        addr = FACT_A_N;
        wd = 9;
        #1;
        check("rw_old", rd, 5);
        @(negedge clk);
        we = 1'b0;
        rd_chk("rw_new", FACT_A_N, 9);

        bus_wr(FACT_A_CTRL, 2);
`ifdef FACT_IF_IRQ_EN
        rd_chk("ie_set", FACT_A_CTRL, 2);
        check("irq_ie", 32'(irq), 1);
`else
        rd_chk("ie_none", FACT_A_CTRL, 0);
`endif
        check("ie_nogo", 32'(go), 0);
        bus_wr(FACT_A_CTRL, 0);
`ifdef FACT_IF_IRQ_EN
        check("irq_ie_clr", 32'(irq), 0);
`endif

        bus_wr(FACT_A_N, 13);
        check("n13", 32'(n), 13);
        bus_wr(FACT_A_CTRL, 1);
        check("err_go", 32'(go), 1);
        rd_chk("err_clr_st", FACT_A_STATUS, 0);
        rd_chk("err_clr_res", FACT_A_RESULT, 0);
        core_done = 1'b1;
        core_err = 1'b1;
        core_result = 55;
        tick();
        core_done = 1'b0;
        core_err = 1'b0;
        core_result = '0;
        rd_chk("err_st", FACT_A_STATUS, 3);
        rd_chk("err_res", FACT_A_RESULT, 0);
        rd_chk("err_idle", FACT_A_CTRL, 0);

        bus_wr(FACT_A_N, 6);
        g0 = go_cnt;
        bus_wr(FACT_A_CTRL, 1);
        bus_wr(FACT_A_CTRL, 1);
        bus_wr(FACT_A_N, 3);
        check("busy_n", 32'(n), 6);
        rd_chk("busy_rd_n", FACT_A_N, 6);
        rd_chk("busy_ctrl", FACT_A_CTRL, 1);
        rd_chk("busy_st", FACT_A_STATUS, 0);
        check("busy_go", 32'(go), 0);
        check("busy_go_cnt", 32'(go_cnt - g0), 1);
        core_done = 1'b1;
        core_result = 720;
        tick();
        core_done = 1'b0;
        rd_chk("res720", FACT_A_RESULT, 720);
        rd_chk("st720", FACT_A_STATUS, 1);
        core_done = 1'b1;
        core_result = 5;
        tick();
        core_done = 1'b0;
        core_result = '0;
        rd_chk("stray_res", FACT_A_RESULT, 720);
        rd_chk("stray_st", FACT_A_STATUS, 1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd_chk("rst2_st", FACT_A_STATUS, 0);
        rd_chk("rst2_res", FACT_A_RESULT, 0);
        rd_chk("rst2_n", FACT_A_N, 0);

        bus_wr(FACT_A_N, 4);
        bus_wr(FACT_A_CTRL, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd_chk("rst3_ctrl", FACT_A_CTRL, 0);
        rd_chk("rst3_st", FACT_A_STATUS, 0);
        rd_chk("rst3_res", FACT_A_RESULT, 0);
        check("rst3_go", 32'(go), 0);
        check("rst3_n", 32'(n), 0);

        bus_wr(FACT_A_N, 4);
        bus_wr(FACT_A_CTRL, 1);
        check("post_go", 32'(go), 1);
        tick();
        core_done = 1'b1;
        core_result = 24;
        tick();
        core_done = 1'b0;
        core_result = '0;
        rd_chk("post_st", FACT_A_STATUS, 1);
        rd_chk("post_res", FACT_A_RESULT, 24);

`ifdef FACT_IF_IRQ_EN
        bus_wr(FACT_A_N, 3);
        bus_wr(FACT_A_CTRL, 3);
        check("irq_start", 32'(irq), 0);
        core_done = 1'b1;
        core_result = 6;
        tick();
        core_done = 1'b0;
        check("irq_done", 32'(irq), 1);
        rd_chk("irq_ctrl", FACT_A_CTRL, 2);
        bus_wr(FACT_A_CTRL, 3);
        check("irq_restart", 32'(irq), 0);
        check("irq_go", 32'(go), 1);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("irq_done2", 32'(irq), 1);
        bus_wr(FACT_A_CTRL, 0);
        check("irq_ieoff", 32'(irq), 0);
        rd_chk("irq_st", FACT_A_STATUS, 1);
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
